// File: rtl/interval_timer_bank.sv
// Bank of NUM_CH interval timers driven by one shared tick prescaler (CLK_FREQ/TICK_FREQ).
// Optional count snapshot logic is built when INTERVAL_TIMER_CAPTURE_EN is defined.
module interval_timer_bank #(
   parameter int CLK_FREQ  = 100_000_000,
   parameter int TICK_FREQ = 1_000_000,
   parameter int NUM_CH    = 4,
   parameter int CNT_W     = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CH-1:0]       start_i,
   input  logic [NUM_CH-1:0]       stop_i,
   input  logic [NUM_CH-1:0]       clr_i,
   input  logic [NUM_CH-1:0]       periodic_i,
   input  logic [NUM_CH*CNT_W-1:0] limit_i,
   input  logic [NUM_CH-1:0]       capture_i,
   output logic [NUM_CH*CNT_W-1:0] count_o,
   output logic [NUM_CH-1:0]       running_o,
   output logic [NUM_CH-1:0]       done_o,
   output logic [NUM_CH-1:0]       expired_o,
   output logic [NUM_CH*CNT_W-1:0] cap_o,
   output logic [NUM_CH-1:0]       cap_valid_o
);

   localparam int DIV = CLK_FREQ / TICK_FREQ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   if (CLK_FREQ % TICK_FREQ != 0) begin : g_bad_freq
      $error("interval_timer_bank: CLK_FREQ must be a multiple of TICK_FREQ");
   end
   if (NUM_CH < 1) begin : g_bad_ch
      $error("interval_timer_bank: NUM_CH must be >= 1");
   end
   if (CNT_W < 2) begin : g_bad_w
      $error("interval_timer_bank: CNT_W must be >= 2");
   end

   logic [PW-1:0] pre;
   logic          tick;

   // With DIV==1 the compare is always true, so pre stays 0 and tick fires every cycle.
   assign tick = (pre == PW'(DIV - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre <= '0;
      end else if (tick) begin
         pre <= '0;
      end else begin
         pre <= pre + PW'(1);
      end
   end

   for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
      logic [1:0]       state;
      logic [CNT_W-1:0] count;
      logic [CNT_W-1:0] limit;
      logic             periodic;
      logic             expired;
      logic [CNT_W-1:0] count_inc;

      assign count_inc = count + CNT_W'(1);

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state    <= ST_IDLE;
            count    <= '0;
            limit    <= '0;
            periodic <= 1'b0;
            expired  <= 1'b0;
         end else begin
            expired <= 1'b0;
            if (clr_i[n]) begin
               state <= ST_IDLE;
               count <= '0;
            end else if (start_i[n]) begin
               state    <= ST_RUN;
               count    <= '0;
               limit    <= limit_i[n*CNT_W +: CNT_W];
               periodic <= periodic_i[n];
            end else if (stop_i[n] && state == ST_RUN) begin
               state <= ST_IDLE;
            end else if (tick && state == ST_RUN) begin
               // A zero limit means free-run: the counter simply wraps and never expires.
               if (limit == '0 || count_inc != limit) begin
                  count <= count_inc;
               end else begin
                  expired <= 1'b1;
                  if (periodic) begin
                     count <= '0;
                  end else begin
                     count <= limit;
                     state <= ST_DONE;
                  end
               end
            end
         end
      end

      assign count_o[n*CNT_W +: CNT_W] = count;
      assign running_o[n]              = (state == ST_RUN);
      assign done_o[n]                 = (state == ST_DONE);
      assign expired_o[n]              = expired;

`ifdef INTERVAL_TIMER_CAPTURE_EN
      logic [CNT_W-1:0] cap;
      logic             cap_valid;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            cap       <= '0;
            cap_valid <= 1'b0;
         end else begin
            cap_valid <= capture_i[n];
            if (capture_i[n]) begin
               cap <= count;
            end
         end
      end

      assign cap_o[n*CNT_W +: CNT_W] = cap;
      assign cap_valid_o[n]          = cap_valid;
`else
      assign cap_o[n*CNT_W +: CNT_W] = '0;
      assign cap_valid_o[n]          = 1'b0;
`endif
   end

`ifndef INTERVAL_TIMER_CAPTURE_EN
   logic unused_capture;
   assign unused_capture = ^capture_i;
`endif

endmodule
